// File: rtl/bram_copy_engine.sv
// bram_copy_engine
//   Streams a software-selected number of words from the RX BRAM (port B) to
//   the TX BRAM (port B) at one word per cycle, with abort support.
//   Optional byte reversal on the write path is compiled in when the macro
//   BRAM_COPY_BYTE_SWAP_EN is defined; otherwise command bit 29 is ignored.
//
// Ports
//   sys_clk_pin  : single clock for all logic
//   sys_rst_pin  : synchronous active-high reset
//   conf_reg_O   : command word  {start[31], abort[30], swap[29], length[DEPTH_LOG2:0]}
//   conf_reg_I   : status word   {busy[31], done[30], error[29], aborted[28], count[DEPTH_LOG2:0]}
//   rx_*_b       : RX BRAM port B (read only; write enables/data tied to 0)
//   tx_*_b       : TX BRAM port B (write only)
module bram_copy_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 11
) (
    input  logic                  sys_clk_pin,
    input  logic                  sys_rst_pin,
    input  logic [31:0]           conf_reg_O,
    output logic [31:0]           conf_reg_I,
    output logic                  rx_en_b,
    output logic [DATA_W/8-1:0]   rx_wen_b,
    output logic [ADDR_W-1:0]     rx_addr_b,
    output logic [DATA_W-1:0]     rx_din_b,
    input  logic [DATA_W-1:0]     rx_dout_b,
    output logic                  tx_en_b,
    output logic [DATA_W/8-1:0]   tx_wen_b,
    output logic [ADDR_W-1:0]     tx_addr_b,
    output logic [DATA_W-1:0]     tx_din_b
);

    localparam int unsigned        NBYTES  = DATA_W / 8;
    localparam int                 IDX_W   = DEPTH_LOG2 + 1;
    localparam logic [IDX_W-1:0]   MAX_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [ADDR_W-1:0]  BYTES_A = ADDR_W'(NBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nxt;

    // Registered command fields
    logic              cmd_start_q, cmd_start_prev, cmd_abort_q;
    logic [IDX_W-1:0]  cmd_len_q;

    // Transfer context
    logic [IDX_W-1:0]  len_q, rd_idx, count_q;
    logic              wr_pend;

    // Sticky status
    logic              busy_q, done_q, err_q, abt_q;

    // Decode
    logic              start_edge, launch, len_zero, len_big;
    logic              rd_en, aborting, finish;
    logic [IDX_W-1:0]  rd_idx_inc;
    logic [DATA_W-1:0] wr_data;

`ifdef BRAM_COPY_BYTE_SWAP_EN
    logic              cmd_swap_q, swap_q;

    function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] w);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < NBYTES; b++)
            r[8*b +: 8] = w[8*(NBYTES-1-b) +: 8];
        return r;
    endfunction

    assign wr_data = swap_q ? byte_rev(rx_dout_b) : rx_dout_b;

    logic unused_cmd;
    assign unused_cmd = &{1'b0, conf_reg_O[28:DEPTH_LOG2+1]};
`else
    assign wr_data = rx_dout_b;

    logic unused_cmd;
    assign unused_cmd = &{1'b0, conf_reg_O[29:DEPTH_LOG2+1]};
`endif

    assign start_edge = cmd_start_q & ~cmd_start_prev;
    assign len_zero   = (cmd_len_q == '0);
    assign len_big    = (cmd_len_q > MAX_LEN);
    assign rd_idx_inc = rd_idx + 1'b1;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        rd_en     = 1'b0;
        aborting  = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    launch = 1'b1;
                    if (!len_zero && !len_big)
                        state_nxt = RUN;
                end
            end
            RUN: begin
                // Abort suppresses this cycle's read; the write for the
                // previous cycle's read still goes out via wr_pend.
                if (cmd_abort_q) begin
                    aborting  = 1'b1;
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    rd_en = 1'b1;
                    if (rd_idx_inc == len_q)
                        state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_en_b   = rd_en;
        rx_wen_b  = '0;
        rx_din_b  = '0;
        rx_addr_b = rd_en ? ADDR_W'(rd_idx) * BYTES_A : '0;
        tx_en_b   = wr_pend;
        tx_wen_b  = wr_pend ? '1 : '0;
        tx_addr_b = wr_pend ? ADDR_W'(count_q) * BYTES_A : '0;
        tx_din_b  = wr_pend ? wr_data : '0;
    end

    always_comb begin
        conf_reg_I               = '0;
        conf_reg_I[31]           = busy_q;
        conf_reg_I[30]           = done_q;
        conf_reg_I[29]           = err_q;
        conf_reg_I[28]           = abt_q;
        conf_reg_I[DEPTH_LOG2:0] = count_q;
    end

    always_ff @(posedge sys_clk_pin) begin
        if (sys_rst_pin) begin
            state          <= IDLE;
            cmd_start_q    <= 1'b0;
            cmd_start_prev <= 1'b0;
            cmd_abort_q    <= 1'b0;
            cmd_len_q      <= '0;
            len_q          <= '0;
            rd_idx         <= '0;
            count_q        <= '0;
            wr_pend        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            abt_q          <= 1'b0;
`ifdef BRAM_COPY_BYTE_SWAP_EN
            cmd_swap_q     <= 1'b0;
            swap_q         <= 1'b0;
`endif
        end else begin
            cmd_start_q    <= conf_reg_O[31];
            cmd_start_prev <= cmd_start_q;
            cmd_abort_q    <= conf_reg_O[30];
            cmd_len_q      <= conf_reg_O[DEPTH_LOG2:0];
`ifdef BRAM_COPY_BYTE_SWAP_EN
            cmd_swap_q     <= conf_reg_O[29];
`endif
            state   <= state_nxt;
            wr_pend <= rd_en;
            if (rd_en)
                rd_idx <= rd_idx_inc;
            if (wr_pend)
                count_q <= count_q + 1'b1;
            if (launch) begin
                len_q   <= cmd_len_q;
                rd_idx  <= '0;
                count_q <= '0;
                abt_q   <= 1'b0;
                err_q   <= len_big;
                done_q  <= len_zero | len_big;
                busy_q  <= ~(len_zero | len_big);
`ifdef BRAM_COPY_BYTE_SWAP_EN
                swap_q  <= cmd_swap_q;
`endif
            end
            if (finish) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                if (aborting)
                    abt_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bram_copy_engine.sv
// Testbench for bram_copy_engine: BRAM behavioural models plus a
// length/abort/swap reference model that predicts the copied image,
// final status word and completion cycle of each transfer.
module tb_bram_copy_engine;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DL    = 11;
    localparam int DEPTH = 2048;
    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    logic          sys_clk_pin = 1'b0;
    logic          sys_rst_pin;
    logic [31:0]   conf_reg_O;
    logic [31:0]   conf_reg_I;
    logic          rx_en_b, tx_en_b;
    logic [3:0]    rx_wen_b, tx_wen_b;
    logic [AW-1:0] rx_addr_b, tx_addr_b;
    logic [DW-1:0] rx_din_b, tx_din_b;
    logic [DW-1:0] rx_dout_b = '0;

    logic [31:0]   rx_mem [DEPTH];
    logic [31:0]   tx_mem [DEPTH];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          n_rd, n_wr, first_rd, first_wr, done_cyc, seq_bad, stray;
        logic [31:0] last_wr_addr, stat_end, stat_c1;
        logic        post_rst;
        bit          timeout;
    } obs_t;

    bram_copy_engine #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL)) dut (
        .sys_clk_pin (sys_clk_pin),
        .sys_rst_pin (sys_rst_pin),
        .conf_reg_O  (conf_reg_O),
        .conf_reg_I  (conf_reg_I),
        .rx_en_b     (rx_en_b),
        .rx_wen_b    (rx_wen_b),
        .rx_addr_b   (rx_addr_b),
        .rx_din_b    (rx_din_b),
        .rx_dout_b   (rx_dout_b),
        .tx_en_b     (tx_en_b),
        .tx_wen_b    (tx_wen_b),
        .tx_addr_b   (tx_addr_b),
        .tx_din_b    (tx_din_b)
    );

    always #5 sys_clk_pin = ~sys_clk_pin;

    // RX BRAM: one-cycle read latency
    always @(posedge sys_clk_pin)
        if (rx_en_b) rx_dout_b <= rx_mem[rx_addr_b[12:2]];

    task automatic step();
        @(posedge sys_clk_pin);
        #1;
    endtask

    function automatic logic [31:0] xform(input logic [31:0] w, input bit swp);
        logic [31:0] r;
        r = w;
`ifdef BRAM_COPY_BYTE_SWAP_EN
        if (swp)
            for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
`endif
        return r;
    endfunction

    // Reference model: words copied, completion cycle and final status
    function automatic void model(input int len, input int ab, output int words,
                                  output int dcyc, output logic [31:0] st);
        st = '0;
        st[30] = 1'b1;
        if (len == 0) begin
            words = 0; dcyc = 1;
        end else if (len > DEPTH) begin
            words = 0; dcyc = 1; st[29] = 1'b1;
        end else if (ab >= 0 && ab + 1 <= len) begin
            words = ab; dcyc = ab + 2; st[28] = 1'b1;
        end else begin
            words = len; dcyc = len + 2;
        end
        st[11:0] = words[11:0];
    endfunction

    function automatic int mem_errs(input int words, input bit swp);
        int e = 0;
        for (int i = 0; i < DEPTH; i++)
            if (tx_mem[i] !== ((i < words) ? xform(rx_mem[i], swp) : SENT)) e++;
        return e;
    endfunction

    // Stimulus driver and observer. Abort/glitch/reset cycles are the cycles
    // in which the raw conf_reg_O / reset value is changed (-1 = never).
    task automatic drive_run(input int len, input bit swp, input int abort_at,
                             input int glitch_at, input int rst_at, output obs_t o);
        logic [31:0] cmd;
        conf_reg_O = '0;
        step(); step(); step();
        for (int i = 0; i < DEPTH; i++) tx_mem[i] = SENT;
        o.n_rd = 0; o.n_wr = 0; o.first_rd = -1; o.first_wr = -1; o.done_cyc = -1;
        o.seq_bad = 0; o.stray = 0; o.last_wr_addr = '0; o.stat_end = '0;
        o.stat_c1 = '0; o.post_rst = 1'b0; o.timeout = 1'b0;
        cmd = '0;
        cmd[31] = 1'b1;
        cmd[29] = swp;
        cmd[11:0] = len[11:0];
        conf_reg_O = cmd;
        step();
        for (int n = 0; n < len + 30; n++) begin
            if (n == abort_at) conf_reg_O[30] = 1'b1;
            if (glitch_at >= 0 && n == glitch_at) conf_reg_O[31] = 1'b0;
            if (glitch_at >= 0 && n == glitch_at + 1) conf_reg_O[31] = 1'b1;
            if (rst_at >= 0 && n == rst_at + 1) begin
                sys_rst_pin = 1'b0;
                o.post_rst = rx_en_b | (|rx_wen_b) | (|rx_addr_b) | (|rx_din_b) |
                             tx_en_b | (|tx_wen_b) | (|tx_addr_b) | (|tx_din_b) |
                             (|conf_reg_I);
            end
            if ((|rx_wen_b) || (|rx_din_b)) o.stray++;
            if (rx_en_b) begin
                if (o.first_rd < 0) o.first_rd = n;
                if (rx_addr_b !== 32'(o.n_rd * 4)) o.seq_bad++;
                o.n_rd++;
            end else if (rx_addr_b !== '0) o.stray++;
            if (tx_en_b) begin
                if (o.first_wr < 0) o.first_wr = n;
                if (tx_wen_b !== 4'hF) o.stray++;
                if (tx_addr_b !== 32'(o.n_wr * 4)) o.seq_bad++;
                if (tx_addr_b < 32'h2000) tx_mem[tx_addr_b[12:2]] = tx_din_b;
                else o.seq_bad++;
                o.last_wr_addr = tx_addr_b;
                o.n_wr++;
            end else if ((|tx_wen_b) || (|tx_addr_b) || (|tx_din_b)) o.stray++;
            if (n == 1) o.stat_c1 = conf_reg_I;
            if (n >= 1 && conf_reg_I[31] == 1'b0) begin
                o.done_cyc = n;
                o.stat_end = conf_reg_I;
                break;
            end
            if (rst_at >= 0 && n == rst_at) sys_rst_pin = 1'b1;
            step();
        end
        if (o.done_cyc < 0) o.timeout = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] all_or;
        sys_rst_pin = 1'b1;
        conf_reg_O  = '0;
        step();
        all_or = {31'b0, rx_en_b | tx_en_b} | 32'(rx_wen_b) | 32'(tx_wen_b) |
                 rx_addr_b | tx_addr_b | rx_din_b | tx_din_b;
        total++;
        if (all_or !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_or); end
        total++;
        if (conf_reg_I !== '0) begin bad++; $display("FAIL reset_status got=%h want=0", conf_reg_I); end
        sys_rst_pin = 1'b0;
        step();
    endtask

    task automatic test_basic();
        obs_t o; int w, d; logic [31:0] st;
        for (int i = 0; i < DEPTH; i++) rx_mem[i] = 32'hA500_0000 + i;
        drive_run(16, 1'b0, -1, -1, -1, o);
        model(16, -1, w, d, st);
        total++;
        if (o.timeout) begin bad++; $display("FAIL basic_timeout got=1 want=0"); end
        total++;
        if (o.first_rd !== 1) begin bad++; $display("FAIL basic_first_rd got=%0d want=1", o.first_rd); end
        total++;
        if (o.first_wr !== 2) begin bad++; $display("FAIL basic_first_wr got=%0d want=2", o.first_wr); end
        total++;
        if (o.done_cyc !== d) begin bad++; $display("FAIL basic_done_cycle got=%0d want=%0d", o.done_cyc, d); end
        total++;
        if (o.stat_end !== st) begin bad++; $display("FAIL basic_status got=%h want=%h", o.stat_end, st); end
        total++;
        if (o.n_wr !== w) begin bad++; $display("FAIL basic_writes got=%0d want=%0d", o.n_wr, w); end
        total++;
        if (o.seq_bad + o.stray !== 0) begin bad++; $display("FAIL basic_bus got=%0d want=0", o.seq_bad + o.stray); end
        total++;
        if (mem_errs(w, 1'b0) !== 0) begin bad++; $display("FAIL basic_mem got=%0d want=0", mem_errs(w, 1'b0)); end
    endtask

    task automatic test_full_depth();
        obs_t o; int w, d; logic [31:0] st;
        for (int i = 0; i < DEPTH; i++) rx_mem[i] = $urandom;
        drive_run(DEPTH, 1'b0, -1, -1, -1, o);
        model(DEPTH, -1, w, d, st);
        total++;
        if (o.stat_end !== st) begin bad++; $display("FAIL full_status got=%h want=%h", o.stat_end, st); end
        total++;
        if (o.last_wr_addr !== 32'h1FFC) begin bad++; $display("FAIL full_last_addr got=%h want=1ffc", o.last_wr_addr); end
        total++;
        if (o.done_cyc !== d) begin bad++; $display("FAIL full_done_cycle got=%0d want=%0d", o.done_cyc, d); end
        total++;
        if (mem_errs(w, 1'b0) + o.seq_bad + o.stray !== 0) begin
            bad++; $display("FAIL full_mem got=%0d want=0", mem_errs(w, 1'b0) + o.seq_bad + o.stray);
        end
        drive_run(DEPTH + 1, 1'b0, -1, -1, -1, o);
        model(DEPTH + 1, -1, w, d, st);
        total++;
        if (o.n_rd + o.n_wr !== 0) begin bad++; $display("FAIL oversize_access got=%0d want=0", o.n_rd + o.n_wr); end
        total++;
        if (o.stat_end !== st) begin bad++; $display("FAIL oversize_status got=%h want=%h", o.stat_end, st); end
        total++;
        if (o.done_cyc !== d) begin bad++; $display("FAIL oversize_done_cycle got=%0d want=%0d", o.done_cyc, d); end
    endtask

    task automatic test_zero_retrigger();
        obs_t o; int w, d; logic [31:0] st; int acc;
        drive_run(0, 1'b0, -1, -1, -1, o);
        model(0, -1, w, d, st);
        total++;
        if (o.done_cyc !== d) begin bad++; $display("FAIL zero_done_cycle got=%0d want=%0d", o.done_cyc, d); end
        total++;
        if (o.stat_end !== st || o.n_rd + o.n_wr !== 0) begin
            bad++; $display("FAIL zero_status got=%h/%0d want=%h/0", o.stat_end, o.n_rd + o.n_wr, st);
        end
        // start still held high: must not re-trigger
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (rx_en_b || tx_en_b || conf_reg_I !== st) acc++;
            step();
        end
        total++;
        if (acc !== 0) begin bad++; $display("FAIL hold_no_retrigger got=%0d want=0", acc); end
        for (int i = 0; i < DEPTH; i++) rx_mem[i] = $urandom;
        drive_run(5, 1'b0, -1, -1, -1, o);
        model(5, -1, w, d, st);
        total++;
        if (o.stat_c1 !== 32'h8000_0000) begin bad++; $display("FAIL rerun_cleared got=%h want=80000000", o.stat_c1); end
        total++;
        if (o.stat_end !== st || mem_errs(w, 1'b0) !== 0) begin
            bad++; $display("FAIL rerun_result got=%h/%0d want=%h/0", o.stat_end, mem_errs(w, 1'b0), st);
        end
    endtask

    task automatic test_abort();
        obs_t o; int w, d; logic [31:0] st;
        drive_run(100, 1'b0, 10, 3, -1, o);
        model(100, 10, w, d, st);
        total++;
        if (o.stat_end !== st) begin bad++; $display("FAIL abort_status got=%h want=%h", o.stat_end, st); end
        total++;
        if (o.n_rd !== w || o.n_wr !== w) begin bad++; $display("FAIL abort_accesses got=%0d/%0d want=%0d", o.n_rd, o.n_wr, w); end
        total++;
        if (o.done_cyc !== d) begin bad++; $display("FAIL abort_done_cycle got=%0d want=%0d", o.done_cyc, d); end
        total++;
        if (mem_errs(w, 1'b0) !== 0) begin bad++; $display("FAIL abort_mem got=%0d want=0", mem_errs(w, 1'b0)); end
    endtask

    task automatic test_swap();
        obs_t o; int w, d; logic [31:0] st; logic [31:0] want;
        for (int i = 0; i < DEPTH; i++) rx_mem[i] = $urandom;
        rx_mem[0] = 32'h1122_3344;
        drive_run(8, 1'b1, -1, -1, -1, o);
        model(8, -1, w, d, st);
`ifdef BRAM_COPY_BYTE_SWAP_EN
        want = 32'h4433_2211;
`else
        want = 32'h1122_3344;
`endif
        total++;
        if (tx_mem[0] !== want) begin bad++; $display("FAIL swap_word0 got=%h want=%h", tx_mem[0], want); end
        total++;
        if (mem_errs(w, 1'b1) !== 0 || o.stat_end !== st) begin
            bad++; $display("FAIL swap_mem got=%0d/%h want=0/%h", mem_errs(w, 1'b1), o.stat_end, st);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o; int w, d; logic [31:0] st;
        drive_run(32, 1'b0, -1, -1, 8, o);
        total++;
        if (o.post_rst !== 1'b0) begin bad++; $display("FAIL midrst_outputs got=%b want=0", o.post_rst); end
        total++;
        if (o.stat_end !== '0 || o.done_cyc !== 9) begin
            bad++; $display("FAIL midrst_status got=%h@%0d want=0@9", o.stat_end, o.done_cyc);
        end
        drive_run(32, 1'b0, -1, -1, -1, o);
        model(32, -1, w, d, st);
        total++;
        if (o.stat_end !== st || mem_errs(w, 1'b0) + o.seq_bad + o.stray !== 0) begin
            bad++; $display("FAIL midrst_rerun got=%h/%0d want=%h/0", o.stat_end,
                            mem_errs(w, 1'b0) + o.seq_bad + o.stray, st);
        end
    endtask

    task automatic test_random();
        obs_t o; int w, d; logic [31:0] st; int len, ab; bit swp;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < DEPTH; i++) rx_mem[i] = $urandom;
            len = int'($urandom_range(1, 40));
            swp = 1'($urandom_range(0, 1));
            ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 45)) : -1;
            drive_run(len, swp, ab, -1, -1, o);
            model(len, ab, w, d, st);
            total++;
            if (o.stat_end !== st || o.done_cyc !== d) begin
                bad++; $display("FAIL random_status len=%0d ab=%0d got=%h@%0d want=%h@%0d",
                                len, ab, o.stat_end, o.done_cyc, st, d);
            end
            total++;
            if (mem_errs(w, swp) + o.seq_bad + o.stray !== 0 || o.n_wr !== w) begin
                bad++; $display("FAIL random_mem len=%0d ab=%0d got=%0d/%0d want=0/%0d",
                                len, ab, mem_errs(w, swp) + o.seq_bad + o.stray, o.n_wr, w);
            end
        end
    endtask

    initial begin
        sys_rst_pin = 1'b1;
        conf_reg_O  = '0;
        for (int i = 0; i < DEPTH; i++) begin rx_mem[i] = '0; tx_mem[i] = SENT; end
        test_reset();
        test_basic();
        test_full_depth();
        test_zero_retrigger();
        test_abort();
        test_swap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
